// File: rtl/uart_rx_framed.sv
// Oversampled UART receiver: start-edge detect, mid-bit sampling, optional parity,
// 1-2 stop bits, with registered data_valid / framing_error / break_detect pulses.
module uart_rx_framed #(
  parameter int DataBits   = 8,
  parameter int Oversample = 16,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_trigger,
  input  logic                raw_data,
  output logic [DataBits-1:0] data,
  output logic                data_valid,
  output logic                parity_error,
  output logic                framing_error,
  output logic                break_detect
);

  if (DataBits < 5 || DataBits > 9) begin : g_bad_databits
    $error("uart_rx_framed: DataBits must be 5..9");
  end
  if (Oversample < 4 || Oversample > 64 || (Oversample % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_framed: Oversample must be even and 4..64");
  end
  if (ParityMode < 0 || ParityMode > 2) begin : g_bad_parity
    $error("uart_rx_framed: ParityMode must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
    $error("uart_rx_framed: StopBits must be 1 or 2");
  end

  localparam int CW = $clog2(Oversample);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DataBits-1:0] data_d;
  logic                prev_q, prev_d;
  logic                perr_q, perr_d;
  logic                bad_q, bad_d;
  logic                one_q, one_d;
  logic                dv_d, pe_d, fe_d, bd_d;
  logic                mid;

  // mid: this trigger lands exactly one bit period after the previous mid-bit sample
  assign mid = (cnt_q == CW'(Oversample - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    prev_d  = prev_q;
    perr_d  = perr_q;
    bad_d   = bad_q;
    one_d   = one_q;
    data_d  = data;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    bd_d    = 1'b0;
    if (sample_trigger) begin
      prev_d = raw_data;
      case (state_q)
        IDLE: begin
          if (prev_q && !raw_data) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CW'(Oversample / 2 - 1)) begin
            cnt_d = '0;
            if (raw_data) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              bit_d   = '0;
              perr_d  = 1'b0;
              bad_d   = 1'b0;
              one_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (mid) begin
            cnt_d   = '0;
            shift_d = {raw_data, shift_q[DataBits-1:1]};
            one_d   = one_q | raw_data;
            if (bit_q == 4'(DataBits - 1)) begin
              bit_d   = '0;
              state_d = (ParityMode == 0) ? STOP : PARITY;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (mid) begin
            cnt_d   = '0;
            one_d   = one_q | raw_data;
            // odd mode flips the expected XOR from 0 to 1
            perr_d  = (^shift_q) ^ raw_data ^ (ParityMode == 2);
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (mid) begin
            cnt_d = '0;
            one_d = one_q | raw_data;
            if (bit_q == 4'(StopBits - 1)) begin
              bit_d = '0;
              if (!bad_q && raw_data) begin
                data_d  = shift_q;
                dv_d    = 1'b1;
                pe_d    = perr_q;
                state_d = IDLE;
              end else if (one_q || raw_data) begin
                fe_d    = 1'b1;
                state_d = IDLE;
              end else begin
                bd_d    = 1'b1;
                state_d = WAIT_IDLE;
              end
            end else begin
              bad_d = bad_q | ~raw_data;
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (raw_data) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // prev_q resets to 0 so a line held low through reset is not taken as a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      prev_q        <= 1'b0;
      perr_q        <= 1'b0;
      bad_q         <= 1'b0;
      one_q         <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      prev_q        <= prev_d;
      perr_q        <= perr_d;
      bad_q         <= bad_d;
      one_q         <= one_d;
      data          <= data_d;
      data_valid    <= dv_d;
      parity_error  <= pe_d;
      framing_error <= fe_d;
      break_detect  <= bd_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench: three receiver configurations share one trigger; stimulus pushes
// expected events, a negedge monitor pops and compares every output pulse.
module tb_uart_rx_framed;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [2:0] raw = 3'b111;
  int         tcnt = 0;

  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic       dv0, pe0, fe0, bd0;
  logic       dv1, pe1, fe1, bd1;
  logic       dv2, pe2, fe2, bd2;

  typedef struct packed {
    logic [1:0] k;   // 1 valid, 2 framing, 3 break
    logic [8:0] d;
    logic       pe;
  } ev_t;

  ev_t q0[$], q1[$], q2[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt <= (tcnt == 9) ? 0 : tcnt + 1;
    trig <= (tcnt == 9);
  end

  uart_rx_framed u0 (
    .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw[0]),
    .data(d0), .data_valid(dv0), .parity_error(pe0),
    .framing_error(fe0), .break_detect(bd0)
  );

  uart_rx_framed #(.DataBits(7), .Oversample(16), .ParityMode(2), .StopBits(2)) u1 (
    .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw[1]),
    .data(d1), .data_valid(dv1), .parity_error(pe1),
    .framing_error(fe1), .break_detect(bd1)
  );

  uart_rx_framed #(.DataBits(8), .Oversample(16), .ParityMode(1), .StopBits(1)) u2 (
    .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw[2]),
    .data(d2), .data_valid(dv2), .parity_error(pe2),
    .framing_error(fe2), .break_detect(bd2)
  );

  task automatic expect_ev(input int id, input logic [1:0] k, input logic [8:0] d, input logic pe);
    ev_t e;
    e.k = k; e.d = d; e.pe = pe;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int id, input logic dv, input logic fe, input logic bd,
                     input logic [8:0] d, input logic pe);
    ev_t e, got;
    int  n;
    bit  ok;
    n  = int'(dv) + int'(fe) + int'(bd);
    ok = 1'b0;
    e  = '0;
    if (n == 0 && pe) begin
      checks++;
      errors++;
      $display("FAIL pe_alone u%0d parity_error=1 without data_valid, want 0", id);
    end
    if (n > 0) begin
      got.k  = dv ? 2'd1 : (fe ? 2'd2 : 2'd3);
      got.d  = d;
      got.pe = pe;
      checks++;
      case (id)
        0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      endcase
      if (!ok) begin
        errors++;
        $display("FAIL unexpected_pulse u%0d got k=%0d d=%h pe=%b, want no pulse", id, got.k, got.d, got.pe);
      end else if (n > 1 || got != e) begin
        errors++;
        $display("FAIL event u%0d got k=%0d d=%h pe=%b pulses=%0d, want k=%0d d=%h pe=%b pulses=1",
                 id, got.k, got.d, got.pe, n, e.k, e.d, e.pe);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, dv0, fe0, bd0, {1'b0, d0}, pe0);
    mon(1, dv1, fe1, bd1, {2'b00, d1}, pe1);
    mon(2, dv2, fe2, bd2, {1'b0, d2}, pe2);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // waits until n sample_trigger pulses have been consumed by the DUTs
  task automatic wait_trig(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!trig) @(negedge clk);
      @(posedge clk);
    end
  endtask

  task automatic line(input int id, input logic v, input int n);
    @(negedge clk);
    raw[id] = v;
    wait_trig(n);
  endtask

  task automatic frame(input int id, input logic [8:0] d, input int nb, input bit has_par,
                       input logic pbit, input logic [1:0] stops, input int ns);
    line(id, 1'b0, 16);
    for (int i = 0; i < nb; i++) line(id, d[i], 16);
    if (has_par) line(id, pbit, 16);
    for (int i = 0; i < ns; i++) line(id, stops[i], 16);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_d0", {24'd0, d0}, 32'd0);
    chk("rst_d1", {25'd0, d1}, 32'd0);
    chk("rst_d2", {24'd0, d2}, 32'd0);
    chk("rst_pulses", {20'd0, dv0, fe0, bd0, pe0, dv1, fe1, bd1, pe1, dv2, fe2, bd2, pe2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_trig(20);

    // 8N1 D5h
    expect_ev(0, 2'd1, 9'h0D5, 1'b0);
    frame(0, 9'h0D5, 8, 1'b0, 1'b0, 2'b11, 1);
    line(0, 1'b1, 20);

    // 7O2 back-to-back: 45h has three ones -> parity 0, 3Ah has four -> parity 1
    expect_ev(1, 2'd1, 9'h045, 1'b0);
    expect_ev(1, 2'd1, 9'h03A, 1'b0);
    frame(1, 9'h045, 7, 1'b1, 1'b0, 2'b11, 2);
    frame(1, 9'h03A, 7, 1'b1, 1'b1, 2'b11, 2);
    line(1, 1'b1, 20);

    // 8E1 C5h has four ones, wrong parity bit 1 -> parity_error
    expect_ev(2, 2'd1, 9'h0C5, 1'b1);
    frame(2, 9'h0C5, 8, 1'b1, 1'b1, 2'b11, 1);
    line(2, 1'b1, 20);

    // stop bit low with ones in data -> framing error, data keeps D5h
    expect_ev(0, 2'd2, 9'h0D5, 1'b0);
    frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b00, 1);
    line(0, 1'b1, 200);

    // long low -> one break, then a good frame after the line recovers
    expect_ev(0, 2'd3, 9'h0D5, 1'b0);
    line(0, 1'b0, 200);
    line(0, 1'b1, 20);
    expect_ev(0, 2'd1, 9'h05A, 1'b0);
    frame(0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
    line(0, 1'b1, 20);

    // start glitch of 4 samples
    line(0, 1'b0, 4);
    line(0, 1'b1, 40);

    // reset during data bit 3 of 33h
    line(0, 1'b0, 16);
    line(0, 1'b1, 16);
    line(0, 1'b1, 16);
    line(0, 1'b0, 16);
    line(0, 1'b0, 8);
    @(negedge clk);
    rst_n = 1'b0;
    raw[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_d0", {24'd0, d0}, 32'd0);
    rst_n = 1'b1;
    line(0, 1'b1, 60);
    chk("after_rst_d0", {24'd0, d0}, 32'd0);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
Parameters (name, default, meaning):
- REQ-001 DataBits, 8, data bits per frame; legal range 5..9.
- REQ-002 Oversample, 16, sample_trigger pulses per bit; legal values are even and 4..64.
- REQ-003 ParityMode, 0, parity mode: 0 none, 1 even, 2 odd.
- REQ-004 StopBits, 1, stop bits per frame; legal values 1 or 2.
- REQ-005 Any illegal parameter value SHALL cause an elaboration-time error.

Ports (name, direction, width, meaning):
- REQ-006 clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-007 rst_n, input, 1, reset: asynchronous assert, active-low.
- REQ-008 sample_trigger, input, 1, one-clk pulse; the only cycles on which raw_data is sampled.
- REQ-009 raw_data, input, 1, serial line; idle high; LSB first.
- REQ-010 data, output, DataBits, last received word; held until the next data_valid.
- REQ-011 data_valid, output, 1, one-clk pulse: data updated.
- REQ-012 parity_error, output, 1, qualifies data_valid; high only in a data_valid cycle.
- REQ-013 framing_error, output, 1, one-clk pulse: a stop bit sampled low (non-break).
- REQ-014 break_detect, output, 1, one-clk pulse: all-zero frame including the stop bits.

Function
- REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; PARITY is skipped when ParityMode=0.
- REQ-016 On clk cycles without sample_trigger, state, counters and the previous-sample register SHALL hold.
- REQ-017 In IDLE, a start edge SHALL be detected when the previous sample is 1 and the current sample is 0; that sample is count 0.
- REQ-018 START: at count Oversample/2, sample 0 SHALL go to DATA; sample 1 (glitch) SHALL return to IDLE with no output pulse.
- REQ-019 Each subsequent bit SHALL be sampled exactly Oversample triggers after the previous mid-bit sample.
- REQ-020 DATA SHALL shift DataBits samples, LSB first, using a bit counter 0..DataBits-1.
- REQ-021 PARITY: even mode expects XOR(data, parity bit)=0; odd mode expects 1; a mismatch latches the parity-error flag.
- REQ-022 STOP SHALL sample StopBits bits; any stop sample of 0 marks the frame bad.
- REQ-023 Good frame: data_valid SHALL pulse on the clk cycle after the last stop mid-sample, with data loaded in that cycle and parity_error driven per REQ-021.
- REQ-024 After the last stop mid-sample the FSM SHALL re-enter IDLE (not wait for bit end); back-to-back frames with no idle gap SHALL be received.
- REQ-025 Bad stop, any data/parity bit 1: framing_error SHALL pulse; data_valid stays 0; data is unchanged; next state IDLE.
- REQ-026 Bad stop, all data, parity and stop samples 0: break_detect SHALL pulse instead of framing_error; next state WAIT_IDLE.
- REQ-027 WAIT_IDLE SHALL go to IDLE on the first sample of 1; no start edge is recognised before that.
- REQ-028 At most one of data_valid, framing_error and break_detect SHALL be high in any cycle.
- REQ-029 Output pulses SHALL be registered; no combinational path from raw_data to any output.

Reset
- REQ-030 rst_n low SHALL asynchronously set: state IDLE; all counters 0; data all-zero; all pulse outputs 0.
- REQ-031 rst_n low SHALL set the previous-sample register to 0, so a line low at reset release is not a start bit until a 1 is seen.
- REQ-032 Reset mid-frame SHALL abandon the frame with no output pulse.
- REQ-033 Reset release SHALL be synchronous-safe; first state change is no earlier than the first sample_trigger after release.

Verification (Oversample=16, sample_trigger period 10 clk)
- REQ-034 8N1 line stream 0,D5h,1 in 16-sample bits -> one data_valid, data=D5h, parity_error=0; no other pulses.
- REQ-035 DataBits=7, ParityMode=2, StopBits=2; frames 45h then 3Ah back-to-back, correct parity -> two data_valid pulses, data=45h then 3Ah.
- REQ-036 ParityMode=1, byte C5h with parity bit 1 -> data_valid with data=C5h and parity_error=1.
- REQ-037 8N1, bits 1's mid-sampled correctly but stop bit low -> framing_error once; data_valid stays 0 for 2000 clk after.
- REQ-038 Line low for 200 samples -> exactly one break_detect, no further pulses; then line high and frame 5Ah -> data_valid, data=5Ah.
- REQ-039 Glitch: 4 low samples then high -> no pulses. Reset asserted at data bit 3 of a frame -> no pulses, and data=0.
